// File: rtl/master_byte_ctrl.sv
// Master byte controller: sequences START, one or more data bytes with
// ACK sampling, and STOP on a 16x oversampled clock. Drives open-drain
// SCL/SDA controls and the load/shift controls of an external PISO.
module master_byte_ctrl (
    input  logic master_scl_sixt,
    input  logic master_rst,
    input  logic master_go,
    input  logic master_byte_valid,
    output logic master_byte_ack,
    output logic master_load_data,
    output logic master_shift_data,
    input  logic master_serial_in_data,
    input  logic master_sda_in,
    output logic master_scl,
    output logic master_sda_oe,
    output logic master_busy,
    output logic master_done,
    output logic master_nack
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DATA  = 3'd3,
        ST_ACK   = 3'd4,
        ST_STOP  = 3'd5
    } state_t;

    state_t     state_r, state_s;
    logic [3:0] tick_r, tick_s;
    logic [2:0] idx_r, idx_s;
    logic       nack_r, nack_s;
    logic       done_r, done_s;
    logic       ack_bit_r, ack_bit_s;

    // State, tick/index counters and status flags; reset lands in IDLE
    // without emitting a STOP condition.
    always_ff @(posedge master_scl_sixt) begin
        if (master_rst) begin
            state_r   <= ST_IDLE;
            tick_r    <= 4'd0;
            idx_r     <= 3'd0;
            nack_r    <= 1'b0;
            done_r    <= 1'b0;
            ack_bit_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            tick_r    <= tick_s;
            idx_r     <= idx_s;
            nack_r    <= nack_s;
            done_r    <= done_s;
            ack_bit_r <= ack_bit_s;
        end
    end

    // Next-state logic: each slot state runs 16 ticks, LOAD is one cycle.
    always_comb begin
        state_s   = state_r;
        tick_s    = tick_r + 4'd1;
        idx_s     = idx_r;
        nack_s    = nack_r;
        ack_bit_s = ack_bit_r;
        done_s    = (state_r == ST_STOP) && (tick_r == 4'd15);
        case (state_r)
            ST_IDLE: begin
                tick_s = 4'd0;
                idx_s  = 3'd0;
                if (master_go && master_byte_valid) begin
                    state_s = ST_START;
                    nack_s  = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_r == 4'd15) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_LOAD: begin
                state_s = ST_DATA;
                idx_s   = 3'd7;
                tick_s  = 4'd0;
            end
            ST_DATA: begin
                if (tick_r == 4'd15) begin
                    if (idx_r == 3'd0) begin
                        state_s = ST_ACK;
                    end else begin
                        idx_s = idx_r - 3'd1;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_ACK: begin
                if (tick_r == 4'd12) begin
                    ack_bit_s = master_sda_in;
                end else begin
                    ack_bit_s = ack_bit_r;
                end
                if (tick_r == 4'd15) begin
                    if (ack_bit_r) begin
                        nack_s  = 1'b1;
                        state_s = ST_STOP;
                    end else if (master_byte_valid) begin
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_STOP;
                    end
                end else begin
                    state_s = ST_ACK;
                end
            end
            ST_STOP: begin
                if (tick_r == 4'd15) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                tick_s  = 4'd0;
                idx_s   = 3'd0;
            end
        endcase
    end

    // Output decode from state/tick/index; only the PISO bit feeds SDA live.
    always_comb begin
        master_scl        = 1'b1;
        master_sda_oe     = 1'b0;
        master_load_data  = 1'b0;
        master_byte_ack   = 1'b0;
        master_shift_data = 1'b0;
        master_busy       = (state_r != ST_IDLE);
        master_done       = done_r;
        master_nack       = nack_r;
        case (state_r)
            ST_IDLE: begin
                master_scl    = 1'b1;
                master_sda_oe = 1'b0;
            end
            ST_START: begin
                master_scl    = 1'b1;
                master_sda_oe = tick_r[3];
            end
            ST_LOAD: begin
                master_scl       = 1'b0;
                master_sda_oe    = 1'b1;
                master_load_data = 1'b1;
                master_byte_ack  = 1'b1;
            end
            ST_DATA: begin
                master_scl        = tick_r[3];
                master_sda_oe     = ~master_serial_in_data;
                master_shift_data = (tick_r == 4'd0) && (idx_r != 3'd7);
            end
            ST_ACK: begin
                master_scl    = tick_r[3];
                master_sda_oe = 1'b0;
            end
            ST_STOP: begin
                master_scl    = tick_r[3];
                master_sda_oe = ~(tick_r[3] & tick_r[2]);
            end
            default: begin
                master_scl    = 1'b1;
                master_sda_oe = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_master_byte_ctrl.sv
// Self-checking bench for master_byte_ctrl: models the PISO, counts
// pulses, measures timing and watches SDA against SCL-high.
module tb_master_byte_ctrl;

    logic clk = 1'b0;
    logic rst, go, sda_in;
    logic byte_valid, byte_ack, load_data, shift_data, serial_in;
    logic scl, sda_oe, busy, done, nack;

    always #5 clk = ~clk;

    master_byte_ctrl dut (
        .master_scl_sixt      (clk),
        .master_rst           (rst),
        .master_go            (go),
        .master_byte_valid    (byte_valid),
        .master_byte_ack      (byte_ack),
        .master_load_data     (load_data),
        .master_shift_data    (shift_data),
        .master_serial_in_data(serial_in),
        .master_sda_in        (sda_in),
        .master_scl           (scl),
        .master_sda_oe        (sda_oe),
        .master_busy          (busy),
        .master_done          (done),
        .master_nack          (nack)
    );

    // Byte source and monitor state
    logic [7:0] bytes_q [0:1];
    int n_bytes = 0, base_ld = 0;
    int cyc = 0, ld_cnt = 0, sh_cnt = 0, ack_cnt = 0, done_cnt = 0;
    int hi_chg = 0, both_cnt = 0, mis_cnt = 0, start_cnt = 0, rise_tot = 0;
    int start_cyc = 0, done_cyc = 0, load_cyc = 0, load_gap = 0, li = 0;
    logic [7:0] shreg = 8'h00;
    logic scl_p = 1'b1, oe_p = 1'b0, busy_p = 1'b0, chk_en = 1'b0;
    logic oe_log [0:1023];
    int total = 0, bad = 0;

    assign byte_valid = ((ld_cnt - base_ld) < n_bytes);
    assign serial_in  = shreg[7];

    always @(posedge clk) cyc <= cyc + 1;

    // PISO model (falling edge) plus pulse/timing/SDA monitors
    always @(negedge clk) begin
        li = ld_cnt - base_ld;
        if (load_data) begin
            shreg    <= bytes_q[li[0]];
            ld_cnt   <= ld_cnt + 1;
            load_gap <= cyc - load_cyc;
            load_cyc <= cyc;
        end else if (shift_data) begin
            shreg <= {shreg[6:0], 1'b0};
        end
        if (shift_data) sh_cnt <= sh_cnt + 1;
        if (byte_ack) ack_cnt <= ack_cnt + 1;
        if (byte_ack !== load_data) mis_cnt <= mis_cnt + 1;
        if (load_data && shift_data) both_cnt <= both_cnt + 1;
        if (busy === 1'b1 && busy_p !== 1'b1) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
        end
        if (done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (chk_en && scl === 1'b1 && scl_p === 1'b1 && sda_oe !== oe_p) hi_chg <= hi_chg + 1;
        if (scl === 1'b1 && scl_p === 1'b0) begin
            oe_log[rise_tot % 1024] <= sda_oe;
            rise_tot <= rise_tot + 1;
        end
        scl_p  <= scl;
        oe_p   <= sda_oe;
        busy_p <= busy;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        int         nb;
        logic       sda;
        logic       noise;
        int         exp_nack;
        int         exp_len;
        int         exp_loads;
        logic [7:0] exp_oe;
    } vec_t;

    vec_t vecs [0:5];

    task automatic run_vec(input vec_t v);
        int b_sh, b_ack, b_done, b_hi, b_rise, b_both, b_mis, t0, k;
        logic [7:0] oe_pat;
        bytes_q[0] = v.b0;
        bytes_q[1] = v.b1;
        base_ld = ld_cnt;
        n_bytes = v.nb;
        sda_in  = v.sda;
        b_sh = sh_cnt; b_ack = ack_cnt; b_done = done_cnt; b_hi = hi_chg;
        b_rise = rise_tot; b_both = both_cnt; b_mis = mis_cnt;
        chk_en = 1'b1;
        check("idle_busy", busy, 0);
        go = 1'b1;
        step(1);
        go = 1'b0;
        t0 = cyc;
        check("start_busy", busy, 1);
        check("start_nack_clr", nack, 0);
        check("start_scl", scl, 1);
        k = 0;
        while (done_cnt == b_done && k < 1000) begin
            go = v.noise && (((cyc - t0) >= 40 && (cyc - t0) <= 45) || (cyc - t0) == 100);
            step(1);
            k++;
        end
        go = 1'b0;
        step(3);
        check("done_pulses", done_cnt - b_done, 1);
        check("txn_len", done_cyc - start_cyc, v.exp_len);
        check("loads", ld_cnt - base_ld, v.exp_loads);
        check("shifts", sh_cnt - b_sh, 7 * v.exp_loads);
        check("byte_acks", ack_cnt - b_ack, v.exp_loads);
        check("last_load_off", load_cyc - start_cyc, 16 + 145 * (v.exp_loads - 1));
        check("nack", nack, v.exp_nack);
        check("end_busy", busy, 0);
        check("sda_hi_changes", hi_chg - b_hi, 2);
        check("load_shift_overlap", both_cnt - b_both, 0);
        check("ack_load_align", mis_cnt - b_mis, 0);
        for (int i = 0; i < 8; i++) oe_pat[7 - i] = oe_log[(b_rise + i) % 1024];
        check("oe_pattern", oe_pat, v.exp_oe);
        if (v.exp_loads == 2) check("load_gap", load_gap, 145);
    endtask

    initial begin
        int b_done, b_start, b_hi, t0, k;
        vecs[0] = '{8'hA5, 8'h00, 1, 1'b0, 1'b0, 0, 177, 1, 8'h5A};
        vecs[1] = '{8'h3C, 8'hFF, 2, 1'b0, 1'b0, 0, 322, 2, 8'hC3};
        vecs[2] = '{8'h00, 8'h00, 1, 1'b1, 1'b0, 1, 177, 1, 8'hFF};
        vecs[3] = '{8'h00, 8'h55, 2, 1'b1, 1'b0, 1, 177, 1, 8'hFF};
        vecs[4] = '{8'hA5, 8'h00, 1, 1'b0, 1'b1, 0, 177, 1, 8'h5A};
        vecs[5] = '{8'hFF, 8'h00, 1, 1'b0, 1'b0, 0, 177, 1, 8'h00};

        rst = 1'b1; go = 1'b0; sda_in = 1'b0;
        step(3);
        check("rst_scl", scl, 1);
        check("rst_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_nack", nack, 0);
        check("rst_load", load_data, 0);
        rst = 1'b0;
        step(2);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);
        check("nack_sticky_idle", nack, 0);

        // go without a valid byte is ignored
        base_ld = ld_cnt; n_bytes = 0; b_start = start_cnt;
        go = 1'b1;
        step(6);
        check("go_novalid_busy", busy, 0);
        check("go_novalid_scl", scl, 1);
        go = 1'b0;
        step(2);
        check("go_novalid_start", start_cnt - b_start, 0);

        // reset in DATA index 3 tick 10
        bytes_q[0] = 8'hA5; base_ld = ld_cnt; n_bytes = 1; sda_in = 1'b0;
        b_done = done_cnt; b_hi = hi_chg;
        go = 1'b1;
        step(1);
        go = 1'b0;
        t0 = cyc;
        k = 0;
        while ((cyc - t0) < 91 && k < 200) begin
            step(1);
            k++;
        end
        check("pre_rst_scl", scl, 1);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_oe", sda_oe, 1);
        chk_en = 1'b0;
        rst = 1'b1;
        step(1);
        check("midrst_scl", scl, 1);
        check("midrst_oe", sda_oe, 0);
        check("midrst_busy", busy, 0);
        check("midrst_shift", shift_data, 0);
        check("midrst_load", load_data, 0);
        check("midrst_done", done, 0);
        rst = 1'b0;
        step(5);
        check("midrst_no_done", done_cnt - b_done, 0);
        check("midrst_idle_busy", busy, 0);
        check("midrst_hi_changes", hi_chg - b_hi, 1);
        chk_en = 1'b1;

        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/master_byte_ctrl.md
MASTER_BYTE_CTRL -- requirements
Module: master_byte_ctrl

Interface
REQ-001 SHALL have ports: master_scl_sixt in 1, the single clock at 16x the SCL bit rate; all logic on its rising edge.
REQ-002 SHALL have master_rst in 1: synchronous, active-high reset.
REQ-003 SHALL have master_go in 1: request to start a transaction, sampled only in IDLE.
REQ-004 SHALL have master_byte_valid in 1: a byte is present on the PISO parallel input.
REQ-005 SHALL have master_byte_ack out 1: one-cycle pulse, byte consumed; coincident with master_load_data.
REQ-006 SHALL have master_load_data out 1 and master_shift_data out 1: controls to the master PISO, which samples them on the falling edge.
REQ-007 SHALL have master_serial_in_data in 1: PISO serial output, the current bit.
REQ-008 SHALL have master_sda_in in 1: sampled SDA bus level.
REQ-009 SHALL have master_scl out 1 and master_sda_oe out 1: open-drain controls; sda_oe=1 pulls SDA low.
REQ-010 SHALL have master_busy out 1, master_done out 1 (pulse), and master_nack out 1 (sticky).

Function
REQ-011 SHALL implement states IDLE, START, LOAD, DATA, ACK, STOP, plus a 4-bit tick counter (0..15) per bit slot and a 3-bit bit index.
REQ-012 All outputs SHALL be decoded from the state, tick and index registers; the only combinational input path is master_serial_in_data to master_sda_oe in DATA.
REQ-013 IDLE: scl=1, sda_oe=0, busy=0, load=shift=0; go=1 with byte_valid=1 enters START at tick 0 next cycle and clears nack; go with byte_valid=0 is ignored.
REQ-014 START: one 16-tick slot; scl=1 throughout; sda_oe=0 for ticks 0-7 and 1 for ticks 8-15 (SDA falls while SCL high); then LOAD.
REQ-015 LOAD: exactly one cycle; scl=0, sda_oe=1; load_data=1 and byte_ack=1; next state DATA, index 7, tick 0.
REQ-016 DATA: 8 slots, index 7 down to 0; scl=0 for ticks 0-7 and 1 for ticks 8-15; sda_oe = NOT master_serial_in_data.
REQ-017 shift_data SHALL be 1 only at tick 0 of the slots with index 6..0 (7 pulses per byte), so PISO data changes only while SCL is low.
REQ-018 load_data and shift_data SHALL never both be 1.
REQ-019 ACK: one slot; sda_oe=0; scl as in DATA; master_sda_in is sampled at tick 12.
REQ-020 At ACK tick 15: a sampled 1 sets nack and goes to STOP; a sampled 0 with byte_valid=1 goes to LOAD; a sampled 0 with byte_valid=0 goes to STOP.
REQ-021 STOP: one slot, driven as follows:
- ticks 0-7: scl=0, sda_oe=1
- ticks 8-11: scl=1, sda_oe=1
- ticks 12-15: scl=1, sda_oe=0 (SDA rises while SCL high)
- then IDLE.
REQ-022 done SHALL pulse one cycle in the first IDLE cycle after STOP; busy=1 in every state except IDLE.
REQ-023 nack SHALL hold until the next accepted go or reset.
REQ-024 Timing: single-byte transaction is 177 cycles from START entry to IDLE; each additional byte adds 145 cycles.
REQ-025 go and byte_valid SHALL be ignored in every state other than their defined sampling points.

Reset
REQ-026 master_rst=1 at any rising edge, including mid-transaction, SHALL force IDLE, tick=0, index=0.
REQ-027 The same reset SHALL force all outputs to: scl=1, sda_oe=0, load=shift=ack=0, busy=0, done=0, nack=0 on the next cycle.
REQ-028 No STOP condition SHALL be generated on reset.

Verification
REQ-029 Single byte 0xA5, slave ACK (sda_in=0 at tick 12):
- exactly 1 load and 7 shift pulses
- sda_oe sequence during SCL-high 0,1,0,1,1,0,1,0
- nack=0
- done pulse 177 cycles after START entry
REQ-030 Two bytes 0x3C then 0xFF, byte_valid held high and ACKed -> second load exactly 145 cycles after the first, byte_ack twice, then STOP.
REQ-031 Byte 0x00 with sda_in=1 at ACK tick 12 -> nack=1, STOP follows directly, nack still 1 after done, cleared on the next accepted go.
REQ-032 Assert master_rst at DATA index 3, tick 10 -> next cycle IDLE, scl=1, sda_oe=0, busy=0, no done pulse.
REQ-033 go=1 with byte_valid=0 in IDLE -> no state change, busy stays 0; go pulses during DATA -> ignored.
REQ-034 A checker on all scenarios SHALL confirm that SDA (sda_oe) never changes while scl=1 except at START tick 8 and STOP tick 12.
